spi_wishbone_master: RTL and testbench
======================================

# spi_wishbone_master

Clock-domain bridge between the SPI slave byte engine and the on-chip Wishbone bus. It consumes the slave's chip-select, byte-boundary strobe and received byte, and decodes the first byte of each frame as a command: bit 7 = write, bits [6:0] = base address. It then issues one classic Wishbone single cycle per subsequent byte with an auto-incrementing address. Read data is returned on `readData` for the slave's `dataToSend` load.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `spiCs` / `spiByteDone` synchronisers (minimum 2).
- `TIMEOUT_CYCLES`, 255: clk cycles a Wishbone cycle may wait for ack/err before it is aborted (1..255).

Ports (one clock, `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `spiCs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `spiByteDone`  in  1  high for at least one sck period after each completed byte; asynchronous.
- `spiDataReceived`  in  8  last received byte; stable while `spiByteDone` is high.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone master controls.
- `wb_adr_o`  out  8  Wishbone address.
- `wb_dat_o`  out  8  write data.
- `wb_dat_i`  in  8  read data.
- `wb_ack_i`, `wb_err_i`  in  1 each  cycle termination.
- `readData`  out  8  last read result, feeds slave `dataToSend`.
- `readValid`  out  1  one-cycle pulse when `readData` updates.
- `busError`  out  1  sticky; set on err or timeout, cleared at next frame start.
- `overrun`  out  1  sticky; a byte event was lost, cleared at next frame start.

## Operation
- `spiCs` and `spiByteDone` each pass through SPI `SYNC_STAGES` flops. A byte event is a synchronised rising edge of `spiByteDone`. `spiDataReceived` is captured into `rxByte` in the same cycle the event is detected.
- State machine:
  - IDLE: entered on reset or when synchronised cs is high and no cycle is in flight. On the synchronised cs falling edge, go to CMD and clear `busError` and `overrun`.
  - CMD: on a byte event, set `isWrite = rxByte[7]` and `addr = {1'b0, rxByte[6:0]}`.
    - Write: go to DATA.
    - Read: go to BUS and prefetch a read at `addr`.
  - DATA: on a byte event, go to BUS.
    - Write: write `rxByte` to `addr`.
    - Read: read `addr`.
  - BUS: `wb_cyc_o = wb_stb_o = 1`, `wb_we_o = isWrite`, `wb_adr_o = addr`, `wb_dat_o = rxByte`. On `wb_ack_i`, `wb_err_i` or timeout, drop cyc/stb and increment `addr` (8-bit, 0xFF wraps to 0x00).
    - Read ack: load `readData` from `wb_dat_i` and pulse `readValid`.
    - err or timeout: set `busError`; `readData` is unchanged.
    - Then go to DATA, or to IDLE if cs went high.
- Ack and err asserted together are treated as err.
- A byte event during BUS sets a one-deep `pending` flag and captures `rxByte`. On BUS exit, a pending event is serviced immediately (BUS re-entered next cycle). A second event while `pending` is set sets `overrun` and is dropped; `rxByte` keeps the first captured value.
- cs rising (synchronised):
  - Outside BUS: go to IDLE immediately and clear `pending`.
  - In BUS: the current cycle completes normally, the pending event is discarded, then IDLE.
- A write frame with only the command byte generates no bus cycle.

## Timing
- Reset values: all `wb_*_o` 0, `readData` 0x00, `readValid` 0, `busError` 0, `overrun` 0, state IDLE, `addr` 0x00. Assertion of `rst_n` clears everything asynchronously, including mid-cycle: cyc/stb drop without waiting for ack.
- Event latency: byte event detected `SYNC_STAGES`+1 clk edges after `spiByteDone` rises. `wb_cyc_o`/`wb_stb_o` assert on the next edge.
- Bus cycle: ack sampled high at edge N drops cyc/stb at edge N (registered, low from N onwards). For reads, `readData`/`readValid` are valid from the same edge N. Minimum cycle is 1 clk with a combinational-ack slave.
- Timeout: counter starts at 0 on BUS entry. Abort at the edge where the count reaches `TIMEOUT_CYCLES` without ack/err.
- The integrating system guarantees sck period ≥ (`SYNC_STAGES`+3) clk periods. For reads to reach the slave before the next byte starts, slave latency must be ≤ one byte time minus sync latency.

## Test plan
- Write burst: frame 0x85, 0xAA, 0xBB, zero-wait slave acks → two writes: adr 0x05 dat 0xAA, then adr 0x06 dat 0xBB, `wb_we_o` = 1; `busError` = 0.
- Read prefetch: frame 0x10, then two dummy bytes; slave returns 0x3C, 0x4D, 0x5E → reads at 0x10, 0x11, 0x12; `readData` sequence 0x3C, 0x4D, 0x5E with one `readValid` pulse each.
- Wrap and timeout: command 0xFF (write addr 0x7F), then 0x7F+1 repeated past 0xFF → address goes 0xFF→0x00. A slave withholding ack for `TIMEOUT_CYCLES` → cyc drops after exactly 255 cycles, `busError` = 1, and the next byte uses the incremented address.
- Overrun: slave stalls 3 byte-times during a write burst → first extra byte served after ack, second sets `overrun` = 1; cleared at next cs fall.
- cs rise mid-cycle: cs deasserted while stb is high with delayed ack → cycle completes on ack, then IDLE, no further cycle. `rst_n` low mid-cycle → all outputs 0 within the same clk edge (async).
- Simultaneous ack and err on a read → treated as err: `busError` = 1, `readData` unchanged, no `readValid`.

Source files
------------

// File: rtl/spi_wishbone_master.sv
// ---------------------------------------------------------------------------
// spi_wishbone_master
//
// Bridges the SPI slave byte engine onto a classic Wishbone bus. The first
// byte of every chip-select frame is a command (bit 7 = write, bits [6:0] =
// base address). Each later byte starts one single Wishbone cycle, and the
// address auto-increments after every cycle. Read frames prefetch at the
// base address as soon as the command arrives, so the SPI slave can shift
// out read data during the next byte.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   spiCs             SPI chip select (active-low), asynchronous
//   spiByteDone       byte-complete strobe from the SPI slave, asynchronous
//   spiDataReceived   last received byte, stable while spiByteDone is high
//   wb_cyc_o/stb_o    Wishbone cycle / strobe (driven together)
//   wb_we_o           Wishbone write enable
//   wb_adr_o          Wishbone address
//   wb_dat_o          Wishbone write data
//   wb_dat_i          Wishbone read data
//   wb_ack_i/err_i    Wishbone cycle termination (err wins over ack)
//   readData          last successful read result, for the slave dataToSend
//   readValid         one-cycle pulse when readData updates
//   busError          sticky: err or timeout seen, cleared at frame start
//   overrun           sticky: byte event lost, cleared at frame start
// ---------------------------------------------------------------------------
module spi_wishbone_master #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spiCs,
    input  logic       spiByteDone,
    input  logic [7:0] spiDataReceived,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i,
    input  logic       wb_err_i,
    output logic [7:0] readData,
    output logic       readValid,
    output logic       busError,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_BUS
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Synchronisers and edge detection
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_bd_sync;
    logic                   r_cs_prev;
    logic                   r_bd_prev;
    logic                   r_evt;
    logic [7:0]             r_evt_byte;

    logic w_cs;
    logic w_bd;
    logic w_evt_det;
    logic w_cs_fall;

    // Main state
    state_t     r_state;
    logic       r_is_write;
    logic [7:0] r_addr;
    logic [7:0] r_rx;
    logic       r_pending;
    logic [7:0] r_pend_byte;
    logic [7:0] r_tcnt;
    logic       r_cyc;
    logic       r_we_o;
    logic [7:0] r_read_data;
    logic       r_read_valid;
    logic       r_bus_error;
    logic       r_overrun;

    logic w_timeout;
    logic w_done;
    logic w_fail;

    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_bd      = r_bd_sync[SYNC_STAGES-1];
    assign w_evt_det = w_bd & ~r_bd_prev;
    assign w_cs_fall = ~w_cs & r_cs_prev;

    // Ack and err together count as err.
    assign w_timeout = (r_tcnt == TO_LAST) & ~wb_ack_i & ~wb_err_i;
    assign w_fail    = wb_err_i | w_timeout;
    assign w_done    = wb_ack_i | w_fail;

    // The detected event and its byte are registered once, so the state
    // machine acts one edge after detection and cyc/stb rise on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync  <= '1;
            r_bd_sync  <= '0;
            r_cs_prev  <= 1'b1;
            r_bd_prev  <= 1'b0;
            r_evt      <= 1'b0;
            r_evt_byte <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], spiCs};
            r_bd_sync <= {r_bd_sync[SYNC_STAGES-2:0], spiByteDone};
            r_cs_prev <= w_cs;
            r_bd_prev <= w_bd;
            r_evt     <= w_evt_det;
            if (w_evt_det) begin
                r_evt_byte <= spiDataReceived;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_rx         <= '0;
            r_pending    <= 1'b0;
            r_pend_byte  <= '0;
            r_tcnt       <= '0;
            r_cyc        <= 1'b0;
            r_we_o       <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pending <= 1'b0;
                    if (w_cs_fall) begin
                        r_state     <= S_CMD;
                        r_bus_error <= 1'b0;
                        r_overrun   <= 1'b0;
                    end
                end

                S_CMD: begin
                    if (w_cs) begin
                        r_state   <= S_IDLE;
                        r_pending <= 1'b0;
                    end else if (r_evt) begin
                        r_rx       <= r_evt_byte;
                        r_is_write <= r_evt_byte[7];
                        r_addr     <= {1'b0, r_evt_byte[6:0]};
                        if (r_evt_byte[7]) begin
                            r_state <= S_DATA;
                        end else begin
                            // Read command: prefetch at the base address.
                            r_state <= S_BUS;
                            r_cyc   <= 1'b1;
                            r_we_o  <= 1'b0;
                            r_tcnt  <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (w_cs) begin
                        r_state   <= S_IDLE;
                        r_pending <= 1'b0;
                    end else if (r_pending || r_evt) begin
                        // A byte held over from the previous cycle goes first.
                        r_rx      <= r_pending ? r_pend_byte : r_evt_byte;
                        r_pending <= 1'b0;
                        r_state   <= S_BUS;
                        r_cyc     <= 1'b1;
                        r_we_o    <= r_is_write;
                        r_tcnt    <= '0;
                    end
                end

                S_BUS: begin
                    if (r_evt) begin
                        if (r_pending) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pending   <= 1'b1;
                            r_pend_byte <= r_evt_byte;
                        end
                    end
                    if (w_done) begin
                        r_cyc  <= 1'b0;
                        r_we_o <= 1'b0;
                        r_addr <= r_addr + 8'd1;
                        if (w_fail) begin
                            r_bus_error <= 1'b1;
                        end else if (!r_is_write) begin
                            r_read_data  <= wb_dat_i;
                            r_read_valid <= 1'b1;
                        end
                        // cs already high: the held byte belongs to a dead
                        // frame, so it is dropped here (overrides the set above).
                        if (w_cs) begin
                            r_state   <= S_IDLE;
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we_o;
    assign wb_adr_o  = r_addr;
    assign wb_dat_o  = r_rx;
    assign readData  = r_read_data;
    assign readValid = r_read_valid;
    assign busError  = r_bus_error;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_spi_wishbone_master.sv
module tb_spi_wishbone_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spiCs = 1'b1;
    logic       spiByteDone = 1'b0;
    logic [7:0] spiDataReceived = 8'h00;
    logic       wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic       wb_ack_i, wb_err_i;
    logic [7:0] readData;
    logic       readValid, busError, overrun;

    always #5 clk = ~clk;

    spi_wishbone_master #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .spiCs(spiCs), .spiByteDone(spiByteDone), .spiDataReceived(spiDataReceived),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .readData(readData), .readValid(readValid),
        .busError(busError), .overrun(overrun)
    );

    // Slave model: terminates a cycle after s_delay wait states.
    int         s_delay = 0;
    logic       s_noack = 1'b0;
    logic       s_err   = 1'b0;
    int         s_cnt   = 0;
    logic [7:0] s_rd [0:255];
    logic [7:0] s_rd_idx = 8'd0;

    assign wb_ack_i = wb_cyc_o & wb_stb_o & ~s_noack & (s_cnt > s_delay);
    assign wb_err_i = wb_cyc_o & wb_stb_o & s_err & (s_cnt > s_delay);
    assign wb_dat_i = s_rd[s_rd_idx];

    // Bus cycle log and readValid log
    logic [7:0] lg_adr [0:1023];
    logic [7:0] lg_dat [0:1023];
    logic       lg_we  [0:1023];
    int         lg_len [0:1023];
    int         log_n = 0;
    logic [7:0] rv_val [0:255];
    int         rv_cnt = 0;
    int         cur_len = 0;
    logic [7:0] cur_adr = 8'h00, cur_dat = 8'h00;
    logic       cur_we = 1'b0, prev_cyc = 1'b0;

    always @(negedge clk) begin
        if (readValid) begin
            rv_val[rv_cnt % 256] = readData;
            rv_cnt++;
        end
        if (wb_cyc_o) begin
            cur_len++;
            cur_adr = wb_adr_o;
            cur_dat = wb_dat_o;
            cur_we  = wb_we_o;
            s_cnt++;
        end else begin
            if (prev_cyc && log_n < 1024) begin
                lg_adr[log_n] = cur_adr;
                lg_dat[log_n] = cur_dat;
                lg_we[log_n]  = cur_we;
                lg_len[log_n] = cur_len;
                log_n++;
                if (!cur_we) s_rd_idx = s_rd_idx + 8'd1;
            end
            cur_len = 0;
            s_cnt   = 0;
        end
        prev_cyc = wb_cyc_o;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spiDataReceived = b;
        spiByteDone = 1'b1;
        repeat (6) @(negedge clk);
        spiByteDone = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        spiCs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        spiCs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int limit, input string name);
        int k = 0;
        while (log_n < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, log_n, n);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        int         nb;
        int         dly;
        logic [7:0] rdv;
        int         n_cyc;
        logic [7:0] adr0;
        logic [7:0] adr1;
        logic       we;
        logic [7:0] wdat;
        int         n_rv;
        logic [7:0] rd;
    } vec_t;

    vec_t vec [0:7];
    int   base, base_rv;
    logic [7:0] ub;

    initial begin
        vec[0] = '{8'h85, 8'hAA, 2, 0, 8'h00, 1, 8'h05, 8'h05, 1'b1, 8'hAA, 0, 8'h00};
        vec[1] = '{8'h80, 8'h5A, 2, 2, 8'h00, 1, 8'h00, 8'h00, 1'b1, 8'h5A, 0, 8'h00};
        vec[2] = '{8'hFF, 8'hC3, 2, 0, 8'h00, 1, 8'h7F, 8'h7F, 1'b1, 8'hC3, 0, 8'h00};
        vec[3] = '{8'h10, 8'h00, 2, 0, 8'h3C, 2, 8'h10, 8'h11, 1'b0, 8'h00, 2, 8'h3D};
        vec[4] = '{8'h22, 8'h00, 1, 1, 8'h77, 1, 8'h22, 8'h22, 1'b0, 8'h00, 1, 8'h77};
        vec[5] = '{8'h81, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h00, 0, 8'h00};
        vec[6] = '{8'h7F, 8'h00, 2, 1, 8'hE0, 2, 8'h7F, 8'h80, 1'b0, 8'h00, 2, 8'hE1};
        vec[7] = '{8'hC0, 8'h0F, 2, 4, 8'h00, 1, 8'h40, 8'h40, 1'b1, 8'h0F, 0, 8'h00};
        for (int i = 0; i < 256; i++) s_rd[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_readData", readData, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busError", busError, 0);
        chk("idle_overrun", overrun, 0);

        // Table-driven single-frame vectors
        for (int i = 0; i < 8; i++) begin
            base = log_n;
            base_rv = rv_cnt;
            s_delay = vec[i].dly;
            s_rd[s_rd_idx] = vec[i].rdv;
            s_rd[s_rd_idx + 8'd1] = vec[i].rdv + 8'd1;
            start_frame();
            send_byte(vec[i].cmd);
            if (vec[i].nb == 2) send_byte(vec[i].dat);
            wait_log(base + vec[i].n_cyc, 200, $sformatf("v%0d_wait", i));
            repeat (30) @(negedge clk);
            chk($sformatf("v%0d_ncyc", i), log_n - base, vec[i].n_cyc);
            if (vec[i].n_cyc > 0) begin
                chk($sformatf("v%0d_adr0", i), lg_adr[base], vec[i].adr0);
                chk($sformatf("v%0d_adr1", i), lg_adr[base + vec[i].n_cyc - 1], vec[i].adr1);
                chk($sformatf("v%0d_we", i), lg_we[base], vec[i].we);
                if (vec[i].we) chk($sformatf("v%0d_wdat", i), lg_dat[base], vec[i].wdat);
            end
            chk($sformatf("v%0d_nrv", i), rv_cnt - base_rv, vec[i].n_rv);
            if (vec[i].n_rv > 0) chk($sformatf("v%0d_rd", i), readData, vec[i].rd);
            chk($sformatf("v%0d_busError", i), busError, 0);
            end_frame();
        end

        // Write burst 0x85 0xAA 0xBB, zero-wait slave
        base = log_n;
        s_delay = 0;
        start_frame();
        send_byte(8'h85);
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_log(base + 2, 200, "wb_wait");
        chk("wb_adr0", lg_adr[base], 8'h05);
        chk("wb_dat0", lg_dat[base], 8'hAA);
        chk("wb_adr1", lg_adr[base + 1], 8'h06);
        chk("wb_dat1", lg_dat[base + 1], 8'hBB);
        chk("wb_we", {lg_we[base], lg_we[base + 1]}, 2'b11);
        chk("wb_len", lg_len[base], 1);
        chk("wb_busError", busError, 0);
        end_frame();

        // Read prefetch 0x10 + two dummy bytes
        base = log_n;
        base_rv = rv_cnt;
        s_rd[s_rd_idx] = 8'h3C;
        s_rd[s_rd_idx + 8'd1] = 8'h4D;
        s_rd[s_rd_idx + 8'd2] = 8'h5E;
        start_frame();
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_log(base + 3, 200, "rp_wait");
        repeat (4) @(negedge clk);
        chk("rp_adr0", lg_adr[base], 8'h10);
        chk("rp_adr1", lg_adr[base + 1], 8'h11);
        chk("rp_adr2", lg_adr[base + 2], 8'h12);
        chk("rp_nrv", rv_cnt - base_rv, 3);
        chk("rp_rd0", rv_val[base_rv % 256], 8'h3C);
        chk("rp_rd1", rv_val[(base_rv + 1) % 256], 8'h4D);
        chk("rp_rd2", rv_val[(base_rv + 2) % 256], 8'h5E);
        end_frame();

        // Address wrap: write from 0x7F through 0xFF to 0x00
        base = log_n;
        start_frame();
        send_byte(8'hFF);
        for (int k = 0; k < 130; k++) begin
            ub = 8'(k);
            send_byte(ub);
        end
        wait_log(base + 130, 200, "wrap_wait");
        chk("wrap_first", lg_adr[base], 8'h7F);
        chk("wrap_ff", lg_adr[base + 128], 8'hFF);
        chk("wrap_00", lg_adr[base + 129], 8'h00);
        chk("wrap_dat", lg_dat[base + 129], 8'h81);
        end_frame();

        // Timeout: slave withholds ack on the first write
        base = log_n;
        s_noack = 1'b1;
        start_frame();
        send_byte(8'h90);
        send_byte(8'h11);
        wait_log(base + 1, 400, "to_wait");
        s_noack = 1'b0;
        chk("to_len", lg_len[base], 255);
        chk("to_adr", lg_adr[base], 8'h10);
        chk("to_busError", busError, 1);
        send_byte(8'h22);
        wait_log(base + 2, 200, "to_wait2");
        chk("to_next_adr", lg_adr[base + 1], 8'h11);
        chk("to_next_dat", lg_dat[base + 1], 8'h22);
        chk("to_sticky", busError, 1);
        end_frame();
        chk("to_after_cs", busError, 1);
        start_frame();
        chk("to_cleared", busError, 0);
        end_frame();

        // Overrun: stalling slave, three bytes during one long cycle
        base = log_n;
        s_delay = 50;
        start_frame();
        send_byte(8'hA0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        wait_log(base + 2, 400, "ov_wait");
        repeat (40) @(negedge clk);
        chk("ov_ncyc", log_n - base, 2);
        chk("ov_adr0", lg_adr[base], 8'h20);
        chk("ov_dat0", lg_dat[base], 8'h01);
        chk("ov_adr1", lg_adr[base + 1], 8'h21);
        chk("ov_dat1", lg_dat[base + 1], 8'h02);
        chk("ov_flag", overrun, 1);
        end_frame();
        chk("ov_sticky", overrun, 1);
        start_frame();
        chk("ov_cleared", overrun, 0);
        end_frame();

        // cs rises while stb is high with a held byte
        base = log_n;
        s_delay = 50;
        start_frame();
        send_byte(8'hB0);
        send_byte(8'h55);
        send_byte(8'h66);
        spiCs = 1'b1;
        chk("csr_inflight", wb_cyc_o, 1);
        repeat (120) @(negedge clk);
        chk("csr_ncyc", log_n - base, 1);
        chk("csr_adr", lg_adr[base], 8'h30);
        chk("csr_dat", lg_dat[base], 8'h55);
        chk("csr_len", lg_len[base], 51);
        repeat (8) @(negedge clk);

        // Asynchronous reset mid-cycle
        chk("pre_rst_rd", readData, 8'h5E);
        s_delay = 50;
        start_frame();
        send_byte(8'hC0);
        send_byte(8'h77);
        chk("ar_cyc_up", wb_cyc_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_cyc", wb_cyc_o, 0);
        chk("ar_stb", wb_stb_o, 0);
        chk("ar_we", wb_we_o, 0);
        chk("ar_adr", wb_adr_o, 0);
        chk("ar_dat", wb_dat_o, 0);
        chk("ar_rd", readData, 0);
        chk("ar_flags", {readValid, busError, overrun}, 3'b000);
        spiCs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Ack and err together on a read count as err
        base = log_n;
        base_rv = rv_cnt;
        s_delay = 0;
        s_err = 1'b1;
        s_rd[s_rd_idx] = 8'h99;
        start_frame();
        send_byte(8'h40);
        wait_log(base + 1, 200, "ae_wait");
        repeat (4) @(negedge clk);
        chk("ae_adr", lg_adr[base], 8'h40);
        chk("ae_busError", busError, 1);
        chk("ae_rd", readData, 8'h00);
        chk("ae_nrv", rv_cnt - base_rv, 0);
        end_frame();
        s_err = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
